mux_scan_sel: RTL and testbench
===============================

# mux_scan_sel

Parametrised, registered N-channel, W-bit multiplexer with a built-in auto-scan sequencer and a valid/ready output handshake. It is the successor of the team's fixed 8:1 single-bit mux. In manual mode it forwards the channel chosen by `S`. In scan mode it steps round-robin through a masked set of channels, waits a programmable settle time on each channel, and emits one sample per channel. It sits between a bank of sensor or data lines and a single-lane consumer such as a serialiser, ADC front-end or logger.

## Interface
- `N`, 8: number of channels, must be ≥ 2.
- `W`, 1: data width per channel.
- `SW`, `$clog2(N)`: select/channel-index width (derived).
- `DW`, 8: width of the dwell counter.
- `CLK`  in  1: single clock; all logic is rising-edge.
- `RST`  in  1: reset, synchronous and active-high.
- `I`  in  N*W: flattened channel inputs; channel k is `I[k*W +: W]`.
- `S`  in  SW: manual channel select; used only when `MODE`=0.
- `MODE`  in  1: 0 = manual, 1 = auto-scan.
- `EN_MASK`  in  N: scan enable per channel; bit k enables channel k.
- `DWELL`  in  DW: number of settle cycles spent on each channel before sampling, in scan mode.
- `READY`  in  1: the consumer accepts `Y` on a cycle where `VALID` and `READY` are both 1.
- `Y`  out  W: registered sample.
- `CH`  out  SW: index of the channel that produced `Y`.
- `VALID`  out  1: `Y` and `CH` hold a sample that has not yet been accepted.

## Operation
- Reset (`RST`=1 at an edge): `Y`=0, `CH`=0, `VALID`=0, internal pointer `PTR`=0, dwell counter=0, FSM in IDLE. Reset overrides every other input, including mid-scan and mid-handshake.
- Slot free: the output slot is free when `VALID`=0, or when `VALID`=1 and `READY`=1 on the same cycle.
- Hold rule: while `VALID`=1 and `READY`=0, `Y` and `CH` are held stable in every mode and state.
- Manual mode (`MODE`=0), FSM held in IDLE:
  - On each edge with the slot free and `S`<N: `Y`←channel `S`, `CH`←`S`, `VALID`←1.
  - If `S`≥N (possible only when N is not a power of 2): `VALID`←0 and `Y`/`CH` keep their values.
- Scan mode FSM:
  - IDLE: if `MODE`=1 and `EN_MASK`≠0, load counter←`DWELL`, select the first enabled channel at or after `PTR` (wrapping) into `PTR`, go to SETTLE. With an all-zero mask, stay in IDLE.
  - SETTLE: if counter≠0, decrement it. If counter=0 and the slot is free, capture `Y`←channel `PTR`, `CH`←`PTR`, `VALID`←1, then go to HOLD.
  - HOLD: when `VALID`=1 and `READY`=1, set `PTR` to the next enabled channel strictly after `PTR`, wrapping to the lowest enabled channel; if only `PTR` is enabled, it re-selects itself. Load counter←`DWELL`, go to SETTLE, `VALID`←0 unless a new capture happens in the same cycle (it cannot, because the counter is freshly loaded; when `DWELL`=0 the capture occurs on the next edge).
- Mask change: if `EN_MASK[PTR]` clears while in SETTLE, advance `PTR` to the next enabled channel and reload the counter on that edge. If the mask becomes all-zero, go to IDLE. A sample already in HOLD is still delivered.
- Mode change:
  - 1→0 in SETTLE: go to IDLE immediately.
  - 1→0 in HOLD: finish the pending handshake, then go to IDLE.
  - 0→1: any pending manual sample must be accepted before the first scan capture (hold rule).
- The counter loads `DWELL` as an unsigned value with no wrap; `DWELL` is sampled only when the counter is loaded.

## Timing
- Manual latency: 1 cycle from `S`/`I` to `Y`/`VALID`. Throughput is 1 sample per cycle when `READY`=1.
- Scan latency: from entering SETTLE to `VALID`=1 is `DWELL`+1 edges.
- Scan throughput with `READY` held at 1: one sample every `DWELL`+2 cycles.
- `I` is sampled only at the capture edge; `VALID` falls no earlier than the edge after acceptance.

## Test plan
- Manual one-hot (N=8, W=1): drive channel k=1 only, `S`=k for k=0..7 over 8 cycles with `READY`=1 → `Y`=1 and `CH`=k, one cycle after each `S`. All inputs 0 → `Y`=0 for every `S`.
- Backpressure: `MODE`=0, capture channel 3 = 1, hold `READY`=0 for 5 cycles while `S` changes → `Y`=1 and `CH`=3 stay stable and `VALID`=1; `READY`=1 → the new `S` is captured on the next edge.
- Scan with mask (N=8, W=4): `EN_MASK`=8'b1010_0101, `DWELL`=2, `READY`=1, channel k = k → `CH` sequence 0,2,5,7,0,…; `Y`=`CH`; `VALID` pulses every 4 cycles.
- Edge cases:
  - `DWELL`=0 with a single enabled channel 6 → `CH`=6 repeatedly, one sample every 2 cycles.
  - `EN_MASK`=0 → `VALID` stays 0 and the FSM stays in IDLE.
- Mid-operation events:
  - Clearing `EN_MASK[PTR]` during SETTLE → that channel is skipped.
  - `MODE` 1→0 in HOLD with `READY`=0 → the sample is held until `READY`, then manual behaviour resumes.
  - `RST` pulse in HOLD → next cycle `Y`=0, `CH`=0, `VALID`=0.

Source files
------------

// File: rtl/mux_scan_sel_if.sv
// Channel bank, control and valid/ready sample port of mux_scan_sel.
// The master drives channels and control. The slave, which is the mux, drives Y/CH/VALID.
interface mux_scan_sel_if #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int DW = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] I;
    logic [SW-1:0]  S;
    logic           MODE;
    logic [N-1:0]   EN_MASK;
    logic [DW-1:0]  DWELL;
    logic           READY;
    logic [W-1:0]   Y;
    logic [SW-1:0]  CH;
    logic           VALID;

    modport master (output I, S, MODE, EN_MASK, DWELL, READY, input Y, CH, VALID);
    modport slave  (input I, S, MODE, EN_MASK, DWELL, READY, output Y, CH, VALID);
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N:1 W-bit mux with a manual select or an auto-scan sequencer.
// The scan sequencer is round-robin over a mask, waits a settle time on each channel, and has a valid/ready output.
module mux_scan_sel #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int DW = 8
) (
    input  logic         CLK,
    input  logic         RST,
    mux_scan_sel_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic            valid_q, valid_d;

    logic mask_any, slot_free, accept;

    assign mask_any  = |bus.EN_MASK;
    assign accept    = valid_q && bus.READY;
    assign slot_free = !valid_q || bus.READY;

    // Find the first enabled channel at or after start (incl=1), or the first strictly after it (incl=0).
    // The search wraps around. For incl=0 the last candidate is start itself, so a lone enabled channel selects itself again.
    function automatic logic [SW-1:0] next_en(input logic [N-1:0] mask,
                                              input logic [SW-1:0] start,
                                              input logic incl);
        logic [SW-1:0] r;
        logic          found;
        int            idx;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k + (incl ? 0 : 1);
            if (idx >= N) idx -= N;
            if (!found && mask[idx]) begin
                r     = SW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.MODE && mask_any) state_d = SETTLE;
            SETTLE: begin
                if (!bus.MODE || !mask_any)
                    state_d = IDLE;
                else if (bus.EN_MASK[ptr_q] && cnt_q == '0 && slot_free)
                    state_d = HOLD;
            end
            HOLD:    if (accept) state_d = (bus.MODE && mask_any) ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An accepted sample is dropped unless a new capture replaces it on the same edge.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = valid_q && !bus.READY;
        unique case (state_q)
            IDLE: begin
                if (bus.MODE) begin
                    if (mask_any) begin
                        cnt_d = bus.DWELL;
                        ptr_d = next_en(bus.EN_MASK, ptr_q, 1'b1);
                    end
                end else if (slot_free && int'(bus.S) < N) begin
                    y_d     = bus.I[int'(bus.S)*W +: W];
                    ch_d    = bus.S;
                    valid_d = 1'b1;
                end
            end
            SETTLE: begin
                if (bus.MODE && mask_any) begin
                    if (!bus.EN_MASK[ptr_q]) begin
                        ptr_d = next_en(bus.EN_MASK, ptr_q, 1'b0);
                        cnt_d = bus.DWELL;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DW'(1);
                    end else if (slot_free) begin
                        y_d     = bus.I[int'(ptr_q)*W +: W];
                        ch_d    = ptr_q;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (accept && bus.MODE && mask_any) begin
                    ptr_d = next_en(bus.EN_MASK, ptr_q, 1'b0);
                    cnt_d = bus.DWELL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.CH    = ch_q;
    assign bus.VALID = valid_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Randomized self-checking bench for mux_scan_sel.
// It compares the DUT against expectations taken straight from the manual, scan and handshake rules.
module tb_mux_scan_sel;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int DW = 8;
    localparam int SW = $clog2(N);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mux_scan_sel_if #(.N(N), .W(W), .DW(DW)) bus ();
    mux_scan_sel #(.N(N), .W(W), .DW(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [W-1:0] chan [N];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_chans();
        for (int k = 0; k < N; k++) bus.I[k*W +: W] = chan[k];
    endtask

    task automatic rand_chans();
        for (int k = 0; k < N; k++) chan[k] = W'($urandom);
        set_chans();
    endtask

    task automatic do_reset();
        bus.MODE = 1'b0; bus.READY = 1'b1; bus.EN_MASK = '0; bus.DWELL = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.MODE = 1'($urandom); bus.READY = 1'($urandom); bus.S = SW'($urandom);
        bus.EN_MASK = N'($urandom); bus.DWELL = DW'($urandom_range(0, 3));
        rand_chans();
        RST = 1'b1;
        tick(); tick();
        checks++; if (bus.Y !== '0) begin errors++; $display("FAIL reset_y got=%0h exp=0", bus.Y); end
        checks++; if (bus.CH !== '0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", bus.CH); end
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.VALID); end
        RST = 1'b0;
    endtask

    task automatic test_manual();
        logic [SW-1:0] s;
        logic [W-1:0]  ey;
        do_reset();
        // one-hot walk: only channel k carries 1, S=k
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) chan[j] = (j == k) ? W'(1) : '0;
            set_chans();
            bus.S = SW'(k);
            tick();
            checks++; if (bus.Y !== W'(1) || bus.CH !== SW'(k) || bus.VALID !== 1'b1) begin
                errors++; $display("FAIL onehot k=%0d got y=%0h ch=%0d v=%0b exp y=1 ch=%0d v=1", k, bus.Y, bus.CH, bus.VALID, k);
            end
        end
        for (int j = 0; j < N; j++) chan[j] = '0;
        set_chans();
        for (int i = 0; i < 4; i++) begin
            bus.S = SW'($urandom_range(0, N-1));
            tick();
            checks++; if (bus.Y !== '0) begin errors++; $display("FAIL zeros got y=%0h exp=0", bus.Y); end
        end
        for (int i = 0; i < 16; i++) begin
            rand_chans();
            s = SW'($urandom_range(0, N-1));
            bus.S = s;
            ey = chan[s];
            tick();
            checks++; if (bus.Y !== ey || bus.CH !== s || bus.VALID !== 1'b1) begin
                errors++; $display("FAIL manual_rand got y=%0h ch=%0d v=%0b exp y=%0h ch=%0d v=1", bus.Y, bus.CH, bus.VALID, ey, s);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s;
        logic [W-1:0]  ey;
        logic [SW-1:0] ec;
        logic          ev, rdy;
        do_reset();
        rand_chans();
        chan[3] = W'($urandom_range(1, (1 << W) - 1));
        set_chans();
        bus.S = SW'(3); bus.READY = 1'b1;
        ey = chan[3];
        tick();
        bus.READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.S = SW'($urandom_range(0, N-1));
            rand_chans();
            tick();
            checks++; if (bus.Y !== ey || bus.CH !== SW'(3) || bus.VALID !== 1'b1) begin
                errors++; $display("FAIL bp_hold got y=%0h ch=%0d v=%0b exp y=%0h ch=3 v=1", bus.Y, bus.CH, bus.VALID, ey);
            end
        end
        bus.READY = 1'b1;
        s = bus.S;
        ey = chan[s];
        tick();
        checks++; if (bus.Y !== ey || bus.CH !== s || bus.VALID !== 1'b1) begin
            errors++; $display("FAIL bp_release got y=%0h ch=%0d exp y=%0h ch=%0d", bus.Y, bus.CH, ey, s);
        end
        // random READY: output slot only refills when empty or being accepted
        ev = 1'b1; ec = s;
        for (int i = 0; i < 30; i++) begin
            rdy = 1'($urandom);
            bus.READY = rdy;
            s = SW'($urandom_range(0, N-1));
            bus.S = s;
            rand_chans();
            if (!(ev && !rdy)) begin ey = chan[s]; ec = s; ev = 1'b1; end
            tick();
            checks++; if (bus.Y !== ey || bus.CH !== ec || bus.VALID !== ev) begin
                errors++; $display("FAIL bp_rand i=%0d got y=%0h ch=%0d v=%0b exp y=%0h ch=%0d v=%0b", i, bus.Y, bus.CH, bus.VALID, ey, ec, ev);
            end
        end
    endtask

    task automatic test_scan(input logic [N-1:0] mask, input int dwell);
        int en[$];
        int p, len, nj, idx;
        logic [SW-1:0] ec;
        do_reset();
        for (int k = 0; k < N; k++) if (mask[k]) en.push_back(k);
        len = en.size();
        p = dwell + 2;
        nj = p * (len + 2) + dwell + 1;
        rand_chans();
        bus.MODE = 1'b1; bus.EN_MASK = mask; bus.DWELL = DW'(dwell); bus.READY = 1'b1;
        tick();
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL scan_enter mask=%0h got v=%0b exp=0", mask, bus.VALID); end
        for (int j = 1; j <= nj; j++) begin
            tick();
            if (j >= dwell + 1 && (j - dwell - 1) % p == 0) begin
                idx = ((j - dwell - 1) / p) % len;
                ec = SW'(en[idx]);
                checks++; if (bus.VALID !== 1'b1 || bus.CH !== ec || bus.Y !== chan[ec]) begin
                    errors++; $display("FAIL scan mask=%0h dwell=%0d j=%0d got v=%0b ch=%0d y=%0h exp v=1 ch=%0d y=%0h",
                                       mask, dwell, j, bus.VALID, bus.CH, bus.Y, ec, chan[ec]);
                end
            end else begin
                checks++; if (bus.VALID !== 1'b0) begin
                    errors++; $display("FAIL scan_gap mask=%0h dwell=%0d j=%0d got v=%0b exp=0", mask, dwell, j, bus.VALID);
                end
            end
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        rand_chans();
        bus.MODE = 1'b1; bus.EN_MASK = '0; bus.DWELL = DW'(1);
        for (int i = 0; i < 12; i++) begin
            bus.READY = 1'($urandom);
            tick();
            checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL mask_zero i=%0d got v=%0b exp=0", i, bus.VALID); end
        end
        bus.READY = 1'b1;
        bus.EN_MASK = N'(8'h10);
        tick(); tick();
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL mask_zero_exit_early got v=%0b exp=0", bus.VALID); end
        tick();
        checks++; if (bus.VALID !== 1'b1 || bus.CH !== SW'(4) || bus.Y !== chan[4]) begin
            errors++; $display("FAIL mask_zero_exit got v=%0b ch=%0d y=%0h exp v=1 ch=4 y=%0h", bus.VALID, bus.CH, bus.Y, chan[4]);
        end
    endtask

    task automatic test_mask_change();
        int dwell;
        dwell = $urandom_range(0, 4);
        do_reset();
        rand_chans();
        bus.MODE = 1'b1; bus.EN_MASK = N'(8'b0111); bus.DWELL = DW'(dwell);
        tick();
        bus.EN_MASK = N'(8'b0110);
        for (int j = 1; j <= dwell + 1; j++) begin
            tick();
            checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL mask_change_wait j=%0d got v=%0b exp=0", j, bus.VALID); end
        end
        tick();
        checks++; if (bus.VALID !== 1'b1 || bus.CH !== SW'(1) || bus.Y !== chan[1]) begin
            errors++; $display("FAIL mask_change_skip got v=%0b ch=%0d y=%0h exp v=1 ch=1 y=%0h", bus.VALID, bus.CH, bus.Y, chan[1]);
        end
    endtask

    task automatic scan_until_valid(input logic [N-1:0] mask, output logic [SW-1:0] lo);
        int n;
        lo = '0;
        for (int k = N - 1; k >= 0; k--) if (mask[k]) lo = SW'(k);
        do_reset();
        rand_chans();
        bus.MODE = 1'b1; bus.EN_MASK = mask; bus.DWELL = DW'($urandom_range(0, 3)); bus.READY = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.VALID !== 1'b1 && n < 20);
        checks++; if (bus.VALID !== 1'b1 || bus.CH !== lo || bus.Y !== chan[lo]) begin
            errors++; $display("FAIL scan_first got v=%0b ch=%0d y=%0h exp v=1 ch=%0d y=%0h", bus.VALID, bus.CH, bus.Y, lo, chan[lo]);
        end
    endtask

    task automatic test_mode_hold();
        logic [SW-1:0] lo, s;
        logic [W-1:0]  ey;
        scan_until_valid(N'($urandom_range(1, (1 << N) - 1)), lo);
        ey = chan[lo];
        bus.MODE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.S = SW'($urandom_range(0, N-1));
            rand_chans();
            tick();
            checks++; if (bus.VALID !== 1'b1 || bus.CH !== lo || bus.Y !== ey) begin
                errors++; $display("FAIL mode_hold got v=%0b ch=%0d y=%0h exp v=1 ch=%0d y=%0h", bus.VALID, bus.CH, bus.Y, lo, ey);
            end
        end
        bus.READY = 1'b1;
        s = SW'($urandom_range(0, N-1));
        bus.S = s;
        tick();
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL mode_hold_accept got v=%0b exp=0", bus.VALID); end
        tick();
        checks++; if (bus.VALID !== 1'b1 || bus.CH !== s || bus.Y !== chan[s]) begin
            errors++; $display("FAIL mode_hold_manual got v=%0b ch=%0d y=%0h exp v=1 ch=%0d y=%0h", bus.VALID, bus.CH, bus.Y, s, chan[s]);
        end
    endtask

    task automatic test_reset_hold();
        logic [SW-1:0] lo;
        scan_until_valid(N'(8'b1100_0000), lo);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (bus.Y !== '0 || bus.CH !== '0 || bus.VALID !== 1'b0) begin
            errors++; $display("FAIL reset_hold got y=%0h ch=%0d v=%0b exp 0/0/0", bus.Y, bus.CH, bus.VALID);
        end
    endtask

    initial begin
        bus.I = '0; bus.S = '0; bus.MODE = 1'b0; bus.EN_MASK = '0; bus.DWELL = '0; bus.READY = 1'b1;
        test_reset();
        test_manual();
        test_backpressure();
        test_scan(N'(8'b1010_0101), 2);
        test_scan(N'(8'b0100_0000), 0);
        for (int r = 0; r < 3; r++) test_scan(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 5));
        test_mask_zero();
        test_mask_change();
        test_mode_hold();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
